// File: rtl/clock_display_pkg.sv
// Shared types and segment constants for the clock display scanner.
package clock_display_pkg;

   typedef enum logic [1:0] {
      SLOT_HR_T = 2'd0,
      SLOT_HR_O = 2'd1,
      SLOT_MN_T = 2'd2,
      SLOT_MN_O = 2'd3
   } slot_t;

   // Segment bit 0 = a ... bit 6 = g, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   typedef struct packed {
      logic       hr_tens;
      logic [3:0] hr_ones;
      logic [2:0] min_tens;
      logic [3:0] min_ones;
      logic       pm;
   } time_t;

   localparam time_t TIME_RESET = '{hr_tens: 1'b1, hr_ones: 4'd2, min_tens: 3'd0,
                                    min_ones: 4'd0, pm: 1'b0};

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
   import clock_display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/clock_display_scan.sv
// 4-digit multiplexed display scanner with frame-coherent time snapshots.
// Optional macro COLON_BLINK_EN: slot-1 dp follows a sec_tick-toggled blink bit.
module clock_display_scan
   import clock_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1024,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hr_tens,
   input  logic [3:0] hr_ones,
   input  logic [2:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic       pm,
   input  logic       time_upd,
   input  logic       sec_tick,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] dig_sel
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   slot_t         slot_q, slot_d;
   time_t         stage_q, stage_d;
   time_t         snap_q, snap_d;
   logic          pending_q, pending_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    dig_q, dig_d;

   time_t         time_in;
   logic          slot_last;
   logic          frame_end;
   logic          active;
   logic          colon;
   logic [3:0]    digit;
   logic [6:0]    dec_seg;

   assign time_in = '{hr_tens: hr_tens, hr_ones: hr_ones, min_tens: min_tens,
                      min_ones: min_ones, pm: pm};

`ifdef COLON_BLINK_EN
   logic blink_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blink_q <= 1'b0;
      else if (sec_tick) blink_q <= ~blink_q;
   end

   assign colon = blink_q;
`else
   logic unused_sec_tick;
   assign unused_sec_tick = sec_tick;
   assign colon = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         slot_q    <= SLOT_HR_T;
         stage_q   <= TIME_RESET;
         snap_q    <= TIME_RESET;
         pending_q <= 1'b0;
         seg_q     <= '0;
         dp_q      <= 1'b0;
         dig_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         stage_q   <= stage_d;
         snap_q    <= snap_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         dig_q     <= dig_d;
      end
   end

   assign slot_last = (cnt_q == CW'(SCAN_DIV - 1));
   assign frame_end = slot_last && (slot_q == SLOT_MN_O);
   assign active    = (cnt_q >= CW'(BLANK_CYCLES));

   // A boundary-coincident update bypasses staging so it lands in this frame edge.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      slot_d    = slot_q;
      stage_d   = stage_q;
      snap_d    = snap_q;
      pending_d = pending_q;
      if (slot_last) begin
         cnt_d  = '0;
         slot_d = slot_t'(slot_q + 2'd1);
      end
      if (time_upd) begin
         stage_d   = time_in;
         pending_d = 1'b1;
      end
      if (frame_end) begin
         pending_d = 1'b0;
         if (time_upd)       snap_d = time_in;
         else if (pending_q) snap_d = stage_q;
      end
   end

   always_comb begin
      digit = snap_q.min_ones;
      case (slot_q)
         SLOT_HR_T: digit = {3'b000, snap_q.hr_tens};
         SLOT_HR_O: digit = snap_q.hr_ones;
         SLOT_MN_T: digit = {1'b0, snap_q.min_tens};
         SLOT_MN_O: digit = snap_q.min_ones;
         default:   digit = snap_q.min_ones;
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd_i (digit),
      .seg_o (dec_seg)
   );

   always_comb begin
      seg_d = '0;
      dp_d  = 1'b0;
      dig_d = '0;
      if (active) begin
         dig_d = 4'b0001 << slot_q;
         seg_d = (slot_q == SLOT_HR_T && !snap_q.hr_tens) ? SEG_BLANK : dec_seg;
         case (slot_q)
            SLOT_HR_O: dp_d = colon;
            SLOT_MN_O: dp_d = snap_q.pm;
            default:   dp_d = 1'b0;
         endcase
      end
   end

   assign seg     = seg_q;
   assign dp      = dp_q;
   assign dig_sel = dig_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan against a cycle-count based reference model.
module tb_clock_display_scan;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FR = 4 * SD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hr_tens = 1'b0;
   logic [3:0] hr_ones = '0;
   logic [2:0] min_tens = '0;
   logic [3:0] min_ones = '0;
   logic       pm = 1'b0;
   logic       time_upd = 1'b0;
   logic       sec_tick = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] dig_sel;

   int checks = 0;
   int passes = 0;

   clock_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hr_tens  (hr_tens),
      .hr_ones  (hr_ones),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .pm       (pm),
      .time_upd (time_upd),
      .sec_tick (sec_tick),
      .seg      (seg),
      .dp       (dp),
      .dig_sel  (dig_sel)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Reference model: t counts clock edges since reset; slot/position follow by division.
   int t;
   int s_ht, s_ho, s_mt, s_mo, s_pm;
   int g_ht, g_ho, g_mt, g_mo, g_pm;
   bit pend, blink;
   logic [11:0] exp_out;

   always @(posedge clk or negedge rst_n) begin : model
      int c, sl, v;
      logic [6:0] sg;
      logic dpv, colon;
      if (!rst_n) begin
         t = 0; s_ht = 1; s_ho = 2; s_mt = 0; s_mo = 0; s_pm = 0;
         pend = 0; blink = 0; exp_out = '0;
      end else begin
         c  = t % SD;
         sl = (t / SD) % 4;
         case (sl)
            0: v = s_ht;  1: v = s_ho;  2: v = s_mt;  default: v = s_mo;
         endcase
         sg = (sl == 0 && s_ht == 0) ? 7'h00 : seg_of(v);
`ifdef COLON_BLINK_EN
         colon = blink;
`else
         colon = 1'b1;
`endif
         dpv = (sl == 3) ? s_pm[0] : ((sl == 1) ? colon : 1'b0);
         exp_out = (c < BC) ? 12'h000 : {sg, dpv, 4'(1 << sl)};
         if (t % FR == FR - 1) begin
            if (time_upd) begin
               s_ht = int'(hr_tens); s_ho = int'(hr_ones); s_mt = int'(min_tens);
               s_mo = int'(min_ones); s_pm = int'(pm);
            end else if (pend) begin
               s_ht = g_ht; s_ho = g_ho; s_mt = g_mt; s_mo = g_mo; s_pm = g_pm;
            end
            pend = 0;
         end else if (time_upd) begin
            pend = 1;
         end
         if (time_upd) begin
            g_ht = int'(hr_tens); g_ho = int'(hr_ones); g_mt = int'(min_tens);
            g_mo = int'(min_ones); g_pm = int'(pm);
         end
         if (sec_tick) blink = !blink;
         t++;
      end
   end

   task automatic set_time(input int ht, input int ho, input int mt, input int mo, input int p);
      hr_tens = 1'(ht); hr_ones = 4'(ho); min_tens = 3'(mt); min_ones = 4'(mo); pm = 1'(p);
   endtask

   task automatic wait_pos(input int pos, input string name);
      int g;
      g = 0;
      while ((t % FR) != pos && g < 4 * FR) begin
         @(negedge clk);
         g++;
      end
      checks++;
      if ((t % FR) != pos) $display("FAIL %s wait timeout pos=%0d want=%0d", name, t % FR, pos);
      else passes++;
   endtask

   task automatic test_reset();
      logic [11:0] want;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({seg, dp, dig_sel} !== 12'h000) $display("FAIL reset_out got=%h exp=000", {seg, dp, dig_sel});
      else passes++;
      rst_n = 1'b1;
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         if (i < 16) begin
            if (i % SD < BC)  want = 12'h000;
            else if (i < SD)  want = {7'h06, 1'b0, 4'b0001};
`ifdef COLON_BLINK_EN
            else              want = {7'h5B, 1'b0, 4'b0010};
`else
            else              want = {7'h5B, 1'b1, 4'b0010};
`endif
            checks++;
            if ({seg, dp, dig_sel} !== want) $display("FAIL reset_scan i=%0d got=%h exp=%h", i, {seg, dp, dig_sel}, want);
            else passes++;
         end
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL reset_model t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
      end
   endtask

   task automatic test_mid_frame_update();
      wait_pos(10, "mid_upd");
      set_time(0, 9, 4, 5, 1);
      time_upd = 1'b1;
      for (int i = 0; i < 3 * FR; i++) begin
         @(negedge clk);
         time_upd = 1'b0;
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL mid_upd t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
      end
   endtask

   task automatic test_boundary_update();
      wait_pos(FR - 1, "bnd_upd");
      set_time(1, 1, 5, 9, 0);
      time_upd = 1'b1;
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         time_upd = 1'b0;
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL bnd_upd t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
      end
   endtask

   task automatic test_dash();
      wait_pos(5, "dash");
      set_time(1, 12, 3, 7, 1);
      time_upd = 1'b1;
      for (int i = 0; i < 2 * FR + 4; i++) begin
         @(negedge clk);
         time_upd = 1'b0;
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL dash t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
      end
   endtask

   task automatic test_blink();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL blink t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
         sec_tick = (i % 100 == 99);
      end
      sec_tick = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL random t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
         set_time(int'($urandom_range(1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));
         time_upd = ($urandom_range(9, 0) == 0);
         sec_tick = ($urandom_range(19, 0) == 0);
      end
      time_upd = 1'b0;
      sec_tick = 1'b0;
   endtask

   task automatic test_reset_mid();
      wait_pos(2 * SD + 3, "rst_mid");
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, dp, dig_sel} !== 12'h000) $display("FAIL rst_mid_async got=%h exp=000", {seg, dp, dig_sel});
      else passes++;
      @(negedge clk);
      checks++;
      if ({seg, dp, dig_sel} !== 12'h000) $display("FAIL rst_mid_hold got=%h exp=000", {seg, dp, dig_sel});
      else passes++;
      rst_n = 1'b1;
      for (int i = 0; i < FR + 8; i++) begin
         @(negedge clk);
         if (i == BC) begin
            checks++;
            if ({seg, dp, dig_sel} !== {7'h06, 1'b0, 4'b0001})
               $display("FAIL rst_mid_restart got=%h exp=%h", {seg, dp, dig_sel}, {7'h06, 1'b0, 4'b0001});
            else passes++;
         end
         checks++;
         if ({seg, dp, dig_sel} !== exp_out) $display("FAIL rst_mid t=%0d got=%h exp=%h", t, {seg, dp, dig_sel}, exp_out);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_mid_frame_update();
      test_boundary_update();
      test_dash();
      test_blink();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
